source_id_arbiter: RTL and testbench

Shares the 16-entry TileLink source-ID pool among up to NUM_REQ L1 adapter channels. It arbitrates allocation requests round-robin and enforces a per-requester outstanding-ID quota. It also sequences the single-request allocate handshake with the pool and forwards releases to the pool's deallocate port. It sits between the L1 adapters and the source-ID pool allocator.

---
 rtl/source_id_arbiter.sv | 143 ++++++++++++++
 tb/tb_source_id_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/source_id_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | source_id_arbiter: round-robin, quota-limited sharing of the source-ID     |
// | pool among L1 adapter channels, with release forwarding to the pool.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module source_id_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 4,
  parameter int QUOTA = 4,
  localparam int IDX_W = $clog2(NUM_REQ),
  localparam int CNT_W = $clog2(QUOTA + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  input  logic               rel_valid,
  input  logic [IDX_W-1:0]   rel_idx,
  input  logic [ID_W-1:0]    rel_id,
  input  logic               pool_avail,
  output logic               pool_alloc_req,
  input  logic               pool_alloc_gnt,
  input  logic [ID_W-1:0]    pool_alloc_id,
  output logic               pool_dealloc_req,
  output logic [ID_W-1:0]    pool_dealloc_id,
  output logic               busy,
  output logic               err_underflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_GRANT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_QUOTA = CNT_W'(QUOTA);
  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]   c_NREQ = (IDX_W + 1)'(NUM_REQ);

  state_t             r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_winner;
  logic [ID_W-1:0]    r_id_q;
  logic [CNT_W-1:0]   r_cnt [NUM_REQ];

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_inc;
  logic [NUM_REQ-1:0] w_dec;
  logic [NUM_REQ-1:0] w_rot;
  logic [IDX_W-1:0]   w_off;
  logic [IDX_W:0]     w_sum;
  logic [IDX_W-1:0]   w_pick;
  logic               w_any;

  // An out-of-range rel_idx matches no requester, so it falls through to underflow.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign w_elig[i] = req[i] && (r_cnt[i] < c_QUOTA);
    assign w_inc[i]  = (r_state == S_GRANT) && (r_winner == IDX_W'(i));
    assign w_dec[i]  = rel_valid && (rel_idx == IDX_W'(i)) && (r_cnt[i] != '0);
  end

  // Rotate eligibility so bit 0 is rr_ptr; the lowest set bit is the offset of the winner.
  assign w_rot = NUM_REQ'({w_elig, w_elig} >> r_rr_ptr);
  assign w_any = |w_elig;

  always_comb begin
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IDX_W'(k);
    end
  end

  assign w_sum  = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_pick = (w_sum >= c_NREQ) ? IDX_W'(w_sum - c_NREQ) : w_sum[IDX_W-1:0];

  assign busy   = (r_state != S_IDLE);
  assign gnt_id = (r_state == S_GRANT) ? r_id_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_rr_ptr       <= '0;
      r_winner       <= '0;
      r_id_q         <= '0;
      gnt            <= '0;
      pool_alloc_req <= 1'b0;
    end else begin
      gnt            <= '0;
      pool_alloc_req <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any && pool_avail) begin
            r_winner       <= w_pick;
            pool_alloc_req <= 1'b1;
            r_state        <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (pool_alloc_gnt) begin
            r_id_q  <= pool_alloc_id;
            gnt     <= NUM_REQ'(1) << r_winner;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_rr_ptr <= (r_winner == c_LAST) ? '0 : r_winner + IDX_W'(1);
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A grant increment and a release decrement on the same requester cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_inc[i] && !w_dec[i]) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        else if (!w_inc[i] && w_dec[i]) r_cnt[i] <= r_cnt[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pool_dealloc_req <= 1'b0;
      pool_dealloc_id  <= '0;
      err_underflow    <= 1'b0;
    end else begin
      pool_dealloc_req <= |w_dec;
      if (|w_dec) pool_dealloc_id <= rel_id;
      if (rel_valid && !(|w_dec)) err_underflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_source_id_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_source_id_arbiter: directed and randomized bench for source_id_arbiter  |
// | against a cycle-numbered transaction model.                                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_source_id_arbiter;

  localparam int N = 4;
  localparam int Q = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [3:0] gnt_id;
  logic       rel_valid = 1'b0;
  logic [1:0] rel_idx = '0;
  logic [3:0] rel_id = '0;
  logic       pool_avail = 1'b1;
  logic       pool_alloc_req;
  logic       pool_alloc_gnt = 1'b0;
  logic [3:0] pool_alloc_id = '0;
  logic       pool_dealloc_req;
  logic [3:0] pool_dealloc_id;
  logic       busy;
  logic       err_underflow;

  source_id_arbiter #(.NUM_REQ(N), .ID_W(4), .QUOTA(Q)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .gnt_id(gnt_id),
    .rel_valid(rel_valid), .rel_idx(rel_idx), .rel_id(rel_id),
    .pool_avail(pool_avail), .pool_alloc_req(pool_alloc_req),
    .pool_alloc_gnt(pool_alloc_gnt), .pool_alloc_id(pool_alloc_id),
    .pool_dealloc_req(pool_dealloc_req), .pool_dealloc_id(pool_dealloc_id),
    .busy(busy), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Pool responder: grants pool_delay cycles after seeing pool_alloc_req.
  bit         auto_pool = 1'b1;
  int         pool_delay = 1;
  int         pool_due = -1;
  bit         fix_id = 1'b0;
  logic [3:0] fixed_id = '0;

  // Reference model: counts per requester plus cycle numbers of the in-flight allocation.
  int         m_cnt [N];
  int         m_rr = 0;
  bit         m_err = 1'b0;
  bit         m_infl = 1'b0;
  int         m_win = 0;
  int         m_issue = -1;
  int         m_grant = -1;
  logic [3:0] m_gid = '0;
  bit         m_dl = 1'b0;
  logic [3:0] m_dlid = '0;
  logic [15:0] exp_vec = '0;
  logic [5:0] held [$];

  function automatic logic [15:0] dut_vec();
    return {gnt, (gnt != 4'h0) ? gnt_id : 4'h0, pool_alloc_req, pool_dealloc_req,
            pool_dealloc_req ? pool_dealloc_id : 4'h0, busy, err_underflow};
  endfunction

  function automatic logic [15:0] model_vec();
    logic [3:0] g;
    g = (m_infl && cyc == m_grant) ? 4'(1 << m_win) : 4'h0;
    return {g, (g != 4'h0) ? m_gid : 4'h0, m_infl && (cyc == m_issue), m_dl,
            m_dl ? m_dlid : 4'h0, m_infl, m_err};
  endfunction

  task automatic model_update();
    int dec_idx;
    bit found;
    int pick;
    if (rst) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_rr = 0; m_err = 0; m_infl = 0; m_win = 0; m_issue = -1; m_grant = -1;
      m_gid = '0; m_dl = 0; m_dlid = '0;
      return;
    end
    dec_idx = -1;
    if (rel_valid) begin
      if (int'(rel_idx) < N && m_cnt[rel_idx] > 0) dec_idx = int'(rel_idx);
      else m_err = 1;
    end
    if (m_infl && cyc == m_grant) begin
      m_cnt[m_win] = m_cnt[m_win] + 1;
      m_rr = (m_win + 1) % N;
      m_infl = 0;
    end else if (!m_infl) begin
      found = 0; pick = 0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (!found && req[j] && m_cnt[j] < Q) begin found = 1; pick = j; end
      end
      if (found && pool_avail) begin
        m_infl = 1; m_win = pick; m_issue = cyc + 1; m_grant = -1;
      end
    end else if (cyc > m_issue && m_grant < 0 && pool_alloc_gnt) begin
      m_grant = cyc + 1;
      m_gid = pool_alloc_id;
    end
    if (dec_idx >= 0) m_cnt[dec_idx] = m_cnt[dec_idx] - 1;
    m_dl = (dec_idx >= 0);
    if (m_dl) m_dlid = rel_id;
  endtask

  task automatic tick();
    bit prev_areq;
    model_update();
    prev_areq = pool_alloc_req;
    @(posedge clk);
    #1;
    cyc++;
    rel_valid = 1'b0;
    if (auto_pool) begin
      if (prev_areq) pool_due = cyc + pool_delay - 1;
      pool_alloc_gnt = (cyc == pool_due);
      pool_alloc_id = fix_id ? fixed_id : 4'($urandom);
    end
    exp_vec = model_vec();
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; rel_valid = 1'b0; pool_avail = 1'b1;
    pool_alloc_gnt = 1'b0; pool_due = -1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; rel_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (dut_vec() !== 16'h0) begin
        fails++; $display("FAIL reset_state cyc=%0d dut=%h exp=%h", cyc, dut_vec(), 16'h0);
      end
    end
    rst = 1'b0;
    tick();
    tests++;
    if (dut_vec() !== exp_vec) begin
      fails++; $display("FAIL reset_idle cyc=%0d dut=%h exp=%h", cyc, dut_vec(), exp_vec);
    end
  endtask

  task automatic test_single();
    int n;
    int areq_cnt;
    do_reset();
    fix_id = 1'b1; fixed_id = 4'h5; pool_delay = 1;
    n = cyc; req = 4'b0100; areq_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      tests++;
      if (dut_vec() !== exp_vec) begin
        fails++; $display("FAIL single_model cyc=%0d dut=%h exp=%h", cyc, dut_vec(), exp_vec);
      end
      if (pool_alloc_req) areq_cnt++;
      if (cyc == n + 3) begin
        tests++;
        if (gnt !== 4'b0100 || gnt_id !== 4'h5) begin
          fails++; $display("FAIL single_grant gnt=%b id=%h exp gnt=0100 id=5", gnt, gnt_id);
        end
        req = '0;
      end
    end
    tests++;
    if (areq_cnt != 1) begin
      fails++; $display("FAIL single_alloc_req_cycles got=%0d exp=1", areq_cnt);
    end
    tests++;
    if (dut.r_cnt[2] !== 2'd1) begin
      fails++; $display("FAIL single_cnt got=%0d exp=1", dut.r_cnt[2]);
    end
    fix_id = 1'b0;
  endtask

  task automatic test_fairness();
    int n;
    int k;
    do_reset();
    n = cyc; req = 4'b1111; k = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests++;
      if (dut_vec() !== exp_vec) begin
        fails++; $display("FAIL fair_model cyc=%0d dut=%h exp=%h", cyc, dut_vec(), exp_vec);
      end
      if (cyc >= n + 3 && ((cyc - n - 3) % 4) == 0 && k < 5) begin
        tests++;
        if (gnt !== 4'(1 << (k % 4))) begin
          fails++; $display("FAIL fair_order k=%0d gnt=%b exp=%b", k, gnt, 4'(1 << (k % 4)));
        end
        k++;
      end
    end
    req = '0;
  endtask

  task automatic test_quota();
    int grants;
    int r;
    do_reset();
    req = 4'b0010; grants = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests++;
      if (dut_vec() !== exp_vec) begin
        fails++; $display("FAIL quota_model cyc=%0d dut=%h exp=%h", cyc, dut_vec(), exp_vec);
      end
      if (gnt[1]) grants++;
    end
    tests++;
    if (grants != 2) begin
      fails++; $display("FAIL quota_limit grants=%0d exp=2", grants);
    end
    rel_valid = 1'b1; rel_idx = 2'd1; rel_id = 4'h3; r = cyc;
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++;
      if (dut_vec() !== exp_vec) begin
        fails++; $display("FAIL quota_rel_model cyc=%0d dut=%h exp=%h", cyc, dut_vec(), exp_vec);
      end
      if (cyc == r + 1) begin
        tests++;
        if (pool_dealloc_req !== 1'b1 || pool_dealloc_id !== 4'h3) begin
          fails++; $display("FAIL quota_dealloc req=%b id=%h exp req=1 id=3", pool_dealloc_req, pool_dealloc_id);
        end
      end
      if (cyc == r + 4) begin
        tests++;
        if (gnt !== 4'b0010) begin
          fails++; $display("FAIL quota_regrant gnt=%b exp=0010", gnt);
        end
        req = '0;
      end
    end
  endtask

  task automatic test_pool_empty();
    int p;
    do_reset();
    pool_avail = 1'b0; req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (busy !== 1'b0 || pool_alloc_req !== 1'b0) begin
        fails++; $display("FAIL empty_hold busy=%b alloc_req=%b exp 0 0", busy, pool_alloc_req);
      end
    end
    pool_avail = 1'b1; p = cyc;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (dut_vec() !== exp_vec) begin
        fails++; $display("FAIL empty_model cyc=%0d dut=%h exp=%h", cyc, dut_vec(), exp_vec);
      end
      if (cyc == p + 1) begin
        tests++;
        if (pool_alloc_req !== 1'b1) begin
          fails++; $display("FAIL empty_start alloc_req=%b exp=1", pool_alloc_req);
        end
      end
      if (cyc == p + 3) req = '0;
    end
  endtask

  task automatic test_simul();
    int n;
    do_reset();
    req = 4'b0001; n = cyc;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (dut_vec() !== exp_vec) begin
        fails++; $display("FAIL simul_model cyc=%0d dut=%h exp=%h", cyc, dut_vec(), exp_vec);
      end
      if (cyc == n + 7) begin
        tests++;
        if (gnt !== 4'b0001) begin
          fails++; $display("FAIL simul_grant gnt=%b exp=0001", gnt);
        end
        rel_valid = 1'b1; rel_idx = 2'd0; rel_id = 4'h9; req = '0;
      end
      if (cyc == n + 8) begin
        tests++;
        if (dut.r_cnt[0] !== 2'd1) begin
          fails++; $display("FAIL simul_cnt got=%0d exp=1", dut.r_cnt[0]);
        end
        tests++;
        if (pool_dealloc_req !== 1'b1 || pool_dealloc_id !== 4'h9) begin
          fails++; $display("FAIL simul_dealloc req=%b id=%h exp req=1 id=9", pool_dealloc_req, pool_dealloc_id);
        end
      end
    end
  endtask

  task automatic test_underflow_reset();
    do_reset();
    rel_valid = 1'b1; rel_idx = 2'd3; rel_id = 4'h7;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (pool_dealloc_req !== 1'b0 || err_underflow !== 1'b1) begin
        fails++; $display("FAIL underflow dealloc=%b err=%b exp 0 1", pool_dealloc_req, err_underflow);
      end
    end
    auto_pool = 1'b0; pool_alloc_gnt = 1'b0; req = 4'b0001;
    tick(); tick();
    tests++;
    if (busy !== 1'b1 || dut_vec() !== exp_vec) begin
      fails++; $display("FAIL wait_state cyc=%0d dut=%h exp=%h", cyc, dut_vec(), exp_vec);
    end
    rst = 1'b1;
    tick();
    tests++;
    if (dut_vec() !== 16'h0) begin
      fails++; $display("FAIL reset_mid_alloc dut=%h exp=%h", dut_vec(), 16'h0);
    end
    rst = 1'b0; req = '0; pool_alloc_gnt = 1'b1; pool_alloc_id = 4'hA;
    tick();
    pool_alloc_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (gnt !== 4'h0 || busy !== 1'b0 || dut_vec() !== exp_vec) begin
        fails++; $display("FAIL stale_pool_gnt cyc=%0d dut=%h exp=%h", cyc, dut_vec(), exp_vec);
      end
    end
    auto_pool = 1'b1;
  endtask

  task automatic test_random();
    int k;
    do_reset();
    held.delete();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) held.push_back({2'(i), gnt_id});
        if (req[i] && gnt[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
      end
      pool_avail = ($urandom_range(0, 9) != 0);
      pool_delay = $urandom_range(1, 3);
      if (held.size() > 0 && $urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, held.size() - 1);
        rel_valid = 1'b1; rel_idx = held[k][5:4]; rel_id = held[k][3:0];
        held.delete(k);
      end else if ($urandom_range(0, 49) == 0) begin
        rel_valid = 1'b1; rel_idx = 2'($urandom); rel_id = 4'($urandom);
      end
      tick();
      tests++;
      if (dut_vec() !== exp_vec) begin
        fails++; $display("FAIL random_model cyc=%0d dut=%h exp=%h", cyc, dut_vec(), exp_vec);
      end
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_quota();
    test_pool_empty();
    test_simul();
    test_underflow_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
